// File: rtl/clm_subbytes_seq_pkg.sv
// Shared types for the CLM masked SubBytes sequencer.
//   M / D        : data byte width and mask redundancy of one masked byte
//   state_t      : one masked byte (M+D bits)
//   block_t      : full AES state, NBYTES_AES masked bytes
//   subbytes_state_t : sequencer FSM states
package clm_subbytes_seq_pkg;
    localparam int M          = 8;
    localparam int D          = 2;
    localparam int NBYTES_AES = 16;

    typedef logic [M+D-1:0]               state_t;
    typedef state_t [NBYTES_AES-1:0]      block_t;

    typedef enum logic [1:0] {
        SB_IDLE,
        SB_ISSUE,
        SB_WAIT,
        SB_DONE
    } subbytes_state_t;
endpackage

// File: rtl/clm_byte_buffer.sv
// NBYTES x W register file holding the masked AES state.
//   i_clk, i_rst_n : clock, async active-low clear (all bytes -> 0)
//   i_load/i_load_data : parallel load of every byte (has priority)
//   i_wr_en/i_wr_idx/i_wr_data : single indexed byte write
//   o_data         : all bytes, continuously
module clm_byte_buffer #(
    parameter int NBYTES = 16,
    parameter int W      = 10,
    parameter int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_load,
    input  logic [NBYTES-1:0][W-1:0]    i_load_data,
    input  logic                        i_wr_en,
    input  logic [IW-1:0]               i_wr_idx,
    input  logic [W-1:0]                i_wr_data,
    output logic [NBYTES-1:0][W-1:0]    o_data
);
    logic [NBYTES-1:0][W-1:0] r_mem;

    for (genvar g = 0; g < NBYTES; g++) begin : g_byte
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n)
                r_mem[g] <= '0;
            else if (i_load)
                r_mem[g] <= i_load_data[g];
            else if (i_wr_en && (i_wr_idx == IW'(g)))
                r_mem[g] <= i_wr_data;
        end
    end

    assign o_data = r_mem;
endmodule

// File: rtl/clm_subbytes_seq.sv
// Byte-serial SubBytes sequencer: captures a masked AES state, hands each
// byte to the external clm_sbox with a drdy_i/drdy_o handshake, writes the
// result back into the same slot and pulses done at the end of the pass.
//   clk, rst            : clock, async active-low reset
//   start, state_in     : begin a pass / state captured on accepted start
//   state_out           : byte buffer (valid from done until next start)
//   busy, done          : pass in progress / one-cycle completion pulse
//   rand_req            : one-cycle pulse to advance the mask source
//   sbox_in, sbox_drdy_i: drive sbox in / drdy_i
//   sbox_out, sbox_drdy_o : sbox out / drdy_o
module clm_subbytes_seq
    import clm_subbytes_seq_pkg::*;
#(
    parameter int d      = D,
    parameter int NBYTES = NBYTES_AES
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [NBYTES-1:0][M+d-1:0]    state_in,
    output logic [NBYTES-1:0][M+d-1:0]    state_out,
    output logic                          busy,
    output logic                          done,
    output logic                          rand_req,
    output logic [M+d-1:0]                sbox_in,
    output logic                          sbox_drdy_i,
    input  logic [M+d-1:0]                sbox_out,
    input  logic                          sbox_drdy_o
);
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    subbytes_state_t          r_state;
    logic [IW-1:0]            r_idx;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_drdy_i;

    logic                     w_load;
    logic                     w_wr;
    logic [NBYTES-1:0][M+d-1:0] w_buf;

    assign w_load = (r_state == SB_IDLE) && start;
    // drdy_o only counts while waiting; elsewhere it is ignored
    assign w_wr   = (r_state == SB_WAIT) && sbox_drdy_o;

    clm_byte_buffer #(
        .NBYTES (NBYTES),
        .W      (M + d),
        .IW     (IW)
    ) u_buf (
        .i_clk       (clk),
        .i_rst_n     (rst),
        .i_load      (w_load),
        .i_load_data (state_in),
        .i_wr_en     (w_wr),
        .i_wr_idx    (r_idx),
        .i_wr_data   (sbox_out),
        .o_data      (w_buf)
    );

    // Outputs are registered alongside the state, set from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= SB_IDLE;
            r_idx    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_drdy_i <= 1'b0;
        end else begin
            r_done   <= 1'b0;
            r_drdy_i <= 1'b0;
            case (r_state)
                SB_IDLE: begin
                    if (start) begin
                        r_state  <= SB_ISSUE;
                        r_idx    <= '0;
                        r_busy   <= 1'b1;
                        r_drdy_i <= 1'b1;
                    end
                end
                SB_ISSUE: r_state <= SB_WAIT;
                SB_WAIT: begin
                    if (sbox_drdy_o) begin
                        if (r_idx == LAST) begin
                            r_state <= SB_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx    <= r_idx + 1'b1;
                            r_state  <= SB_ISSUE;
                            r_drdy_i <= 1'b1;
                        end
                    end
                end
                SB_DONE: begin
                    r_state <= SB_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= SB_IDLE;
            endcase
        end
    end

    // idx only moves after write-back, so sbox_in holds through POW2 and MUL1
    assign sbox_in     = w_buf[r_idx];
    assign state_out   = w_buf;
    assign busy        = r_busy;
    assign done        = r_done;
    assign sbox_drdy_i = r_drdy_i;
    assign rand_req    = w_wr;
endmodule

// File: tb/tb_clm_subbytes_seq.sv
module tb_clm_subbytes_seq;
    import clm_subbytes_seq_pkg::*;

    localparam int W = M + D;

    logic   clk = 1'b0;
    logic   rst = 1'b0;
    logic   start = 1'b0;
    block_t state_in = '0;
    block_t state_out;
    logic   busy, done, rand_req, sbox_drdy_i;
    state_t sbox_in;
    state_t sbox_out = '0;
    logic   mdl_rdy = 1'b0;
    logic   spur = 1'b0;
    logic   sbox_drdy_o;

    int n_chk = 0;
    int n_pass = 0;

    assign sbox_drdy_o = mdl_rdy | spur;

    always #5 clk = ~clk;

    clm_subbytes_seq dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .state_in    (state_in),
        .state_out   (state_out),
        .busy        (busy),
        .done        (done),
        .rand_req    (rand_req),
        .sbox_in     (sbox_in),
        .sbox_drdy_i (sbox_drdy_i),
        .sbox_out    (sbox_out),
        .sbox_drdy_o (sbox_drdy_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // GF(2^8) arithmetic, AES polynomial
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] aes_sbox(input logic [7:0] x);
        logic [7:0] inv = 8'h01;
        logic [7:0] s;
        for (int i = 0; i < 254; i++) inv = gmul(inv, x);   // x^254 = x^-1, 0 -> 0
        s = inv;
        for (int k = 1; k <= 4; k++) s ^= (inv << k) | (inv >> (8 - k));
        return s ^ 8'h63;
    endfunction

    // mask bits pass through; the data byte goes through the AES S-box
    function automatic state_t sbox_ref(input state_t x);
        return {x[W-1:M], aes_sbox(x[M-1:0])};
    endfunction

    // Behavioural sbox: drdy_o six cycles after drdy_i, checks that its
    // input stays put until the result is taken.
    int     mdl_t = 0;
    logic   mdl_pend = 1'b0;
    state_t mdl_lat = '0;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mdl_pend <= 1'b0;
            mdl_rdy  <= 1'b0;
            mdl_t    <= 0;
        end else begin
            mdl_rdy <= 1'b0;
            if (mdl_rdy) chk("sbox_in_hold_wb", sbox_in, mdl_lat);
            if (sbox_drdy_i) begin
                mdl_pend <= 1'b1;
                mdl_t    <= 1;
                mdl_lat  <= sbox_in;
            end else if (mdl_pend) begin
                chk("sbox_in_hold", sbox_in, mdl_lat);
                if (mdl_t == 5) begin
                    mdl_rdy  <= 1'b1;
                    sbox_out <= sbox_ref(mdl_lat);
                    mdl_pend <= 1'b0;
                end
                mdl_t <= mdl_t + 1;
            end
        end
    end

    function automatic block_t rand_block();
        block_t b;
        for (int i = 0; i < NBYTES_AES; i++) b[i] = state_t'($urandom);
        return b;
    endfunction

    // Run one pass; called at #1 after an edge. Cycle 1 is the cycle after
    // the start edge. abort_cyc != 0 pulls reset at that cycle and returns.
    task automatic run_pass(input block_t din, input bit ign_start, input bit spur_issue,
                            input int abort_cyc, output block_t exp);
        block_t alt;
        for (int i = 0; i < NBYTES_AES; i++) exp[i] = sbox_ref(din[i]);
        alt = rand_block();
        state_in = din;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= 115; cyc++) begin
            if (cyc == abort_cyc) begin
                rst = 1'b0;
                @(negedge clk);
                chk("abort_busy", busy, 1'b0);
                chk("abort_done", done, 1'b0);
                chk("abort_drdy", sbox_drdy_i, 1'b0);
                chk("abort_rreq", rand_req, 1'b0);
                chk("abort_out", {63'b0, |state_out}, 64'd0);
                chk("abort_sbin", sbox_in, '0);
                @(posedge clk); @(posedge clk); #1;
                rst = 1'b1;
                @(posedge clk); #1;
                return;
            end
            if (spur_issue && (cyc % 7 == 1) && cyc <= 106) spur = 1'b1;
            if (ign_start && cyc == 50) begin
                start = 1'b1;
                state_in = alt;
            end
            @(negedge clk);
            chk("drdy_i", sbox_drdy_i, (cyc % 7 == 1) && cyc <= 106);
            chk("rand_req", rand_req, (cyc % 7 == 0) && cyc >= 7 && cyc <= 112);
            chk("done", done, cyc == 113);
            chk("busy", busy, cyc <= 113);
            @(posedge clk); #1;
            spur = 1'b0;
            start = 1'b0;
        end
        for (int i = 0; i < NBYTES_AES; i++) chk("result", state_out[i], exp[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        block_t din, exp, prev;
        logic [7:0] tbl [16];
        tbl = '{8'h63, 8'h7C, 8'h77, 8'h7B, 8'hF2, 8'h6B, 8'h6F, 8'hC5,
                8'h30, 8'h01, 8'h67, 8'h2B, 8'hFE, 8'hD7, 8'hAB, 8'h76};

        // reset held with start high
        rst = 1'b0;
        start = 1'b1;
        state_in = rand_block();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_rreq", rand_req, 1'b0);
        chk("rst_drdy", sbox_drdy_i, 1'b0);
        chk("rst_out", {63'b0, |state_out}, 64'd0);
        chk("rst_sbin", sbox_in, '0);
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // directed: 00..0F, zero masks, against the FIPS-197 table
        for (int i = 0; i < NBYTES_AES; i++) din[i] = state_t'(i);
        run_pass(din, 1'b0, 1'b0, 0, exp);
        for (int i = 0; i < NBYTES_AES; i++) begin
            chk("fips_byte", state_out[i][M-1:0], tbl[i]);
            chk("fips_mask", state_out[i][W-1:M], '0);
        end

        // random passes, one with a start ignored mid-pass, one with
        // spurious ready during every ISSUE cycle
        run_pass(rand_block(), 1'b0, 1'b0, 0, exp);
        run_pass(rand_block(), 1'b1, 1'b0, 0, exp);
        run_pass(rand_block(), 1'b0, 1'b1, 0, exp);
        prev = exp;

        // spurious ready while idle: nothing moves
        spur = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("idle_spur_busy", busy, 1'b0);
        chk("idle_spur_rreq", rand_req, 1'b0);
        chk("idle_spur_sbin", sbox_in, prev[NBYTES_AES-1]);
        for (int i = 0; i < NBYTES_AES; i++) chk("idle_spur_buf", state_out[i], prev[i]);
        @(posedge clk); #1;
        spur = 1'b0;
        @(posedge clk); #1;

        // mid-pass reset at cycle 40, then a clean full pass
        run_pass(rand_block(), 1'b0, 1'b0, 40, exp);
        run_pass(rand_block(), 1'b0, 1'b0, 0, exp);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/clm_subbytes_seq.md
# clm_subbytes_seq

Byte-serial SubBytes sequencer for the CLM masked AES datapath. It captures a 16-byte masked state and feeds each masked byte in turn to `clm_sbox` using the sbox's `drdy_i`/`drdy_o` handshake. It writes each sbox result back into the same byte slot and signals completion. It sits directly upstream of `clm_sbox`, between the round-state register and the ShiftRows/MixColumns stage.

## Interface
Parameters:
- `d`, default `d` (package value): mask redundancy; sets the `state_t` width (m+d bits, m=8).
- `NBYTES`, default 16: number of state bytes processed per `start`.

Ports:
- `clk` input 1: clock; all logic on rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `start` input 1: begin a SubBytes pass; sampled only in `SB_IDLE`.
- `state_in` input `block_t`: `NBYTES` × `state_t` masked bytes; captured on the accepted `start` edge.
- `state_out` output `block_t`: internal byte buffer, driven continuously; valid when `done`=1 and afterwards until the next accepted `start`.
- `busy` output 1: high in every state except `SB_IDLE`.
- `done` output 1: single-cycle pulse after the last byte is written back.
- `rand_req` output 1: single-cycle pulse telling the mask source to advance `r` for the next byte.
- `sbox_in` output `state_t`: drives sbox `in`.
- `sbox_drdy_i` output 1: drives sbox `drdy_i`.
- `sbox_out` input `state_t`: sbox `out`.
- `sbox_drdy_o` input 1: sbox `drdy_o`.

## Operation
- FSM states in `subbytes_state_t`: `SB_IDLE`, `SB_ISSUE`, `SB_WAIT`, `SB_DONE`. Byte index `idx` is `$clog2(NBYTES)` bits.
- `SB_IDLE`:
  - If `start`=1: load buffer ← `state_in`, set `idx` ← 0, go to `SB_ISSUE`.
  - Otherwise stay in `SB_IDLE`.
- `SB_ISSUE`: `sbox_drdy_i`=1 for exactly one cycle; always go to `SB_WAIT`.
- `SB_WAIT`:
  - `sbox_drdy_i`=0.
  - On `sbox_drdy_o`=1: buffer[`idx`] ← `sbox_out` and `rand_req`=1 in that cycle.
  - Then, if `idx`=NBYTES−1, go to `SB_DONE`; otherwise `idx` ← `idx`+1 and go to `SB_ISSUE`.
- `SB_DONE`: `done`=1 for one cycle; go to `SB_IDLE`.
- `sbox_in` = buffer[`idx`] in every state. It is stable from `SB_ISSUE` until the write-back, because the sbox reads `in` during both its POW2 and MUL1 cycles.
- Ignored inputs:
  - `start` while `busy`=1 (no re-capture, no restart).
  - `sbox_drdy_o` in any state other than `SB_WAIT`.
- The sequencer does not count the sbox stages. Its correctness relies on the sbox being in POW2 whenever `SB_ISSUE` is entered, which holds after reset and after every AFF cycle.
- `rst` low at any time:
  - FSM → `SB_IDLE`, `idx` → 0.
  - Buffer, `state_out` → all zero.
  - `busy`, `done`, `rand_req`, `sbox_drdy_i` → 0; `sbox_in` → 0.
  - The sbox must be reset in the same cycle; the top level ties sbox `rst` to `~rst`.

## Timing
- `start` sampled at edge 0 → `SB_ISSUE` in cycle 1.
- Per byte: `SB_ISSUE` (sbox POW2) at cycle c; `sbox_drdy_o` arrives at c+6 (sbox AFF); next `SB_ISSUE` at c+7. That is 7 cycles per byte.
- Byte i: issued at cycle 1+7i, written back at edge 7+7i.
- `done` at cycle 113 for NBYTES=16; `busy` high for cycles 1–113.
- A new `start` is accepted no earlier than cycle 114. Back-to-back throughput is 114 cycles per pass.
- `rand_req` pulses at cycles 7+7i. The mask source must present the new `r` by the next `SB_ISSUE` and hold it for the full 7-cycle byte.
- No combinational path from `sbox_drdy_o` to `sbox_drdy_i`.

## Structure
- Add to `types` package:
  - `subbytes_state_t` enum.
  - `NBYTES_AES` = 16.
  - `block_t` (`state_t [NBYTES_AES-1:0]`).
- No new multiplier or power instances; the sbox is instantiated by the parent, not inside this block.
- One natural sub-module: `clm_byte_buffer`, an NBYTES × `state_t` register file with active-low async clear, parallel load, and single indexed write port.

## Test plan
- Reset: hold `rst`=0 with `start`=1 → `busy`=`done`=`rand_req`=0, `state_out`=0, `sbox_drdy_i`=0.
- Functional: `state_in` = masked encoding of 00,01,…,0F with zero masks → after 113 cycles `done`=1. Unmasking `state_out` gives 63,7C,77,7B,F2,6B,6F,C5,30,01,67,2B,FE,D7,AB,76.
- Handshake timing: check `sbox_drdy_i` pulses exactly at cycles 1,8,…,106 and `rand_req` exactly at 7,14,…,112; check `sbox_in` is constant between each `SB_ISSUE` and its write-back.
- Ignored start: pulse `start` with a different `state_in` at cycle 50 → no effect; results match the first capture; `done` still at 113.
- Mid-pass reset: assert `rst`=0 at cycle 40 for 2 cycles, then `start` → clean full pass; `done` 113 cycles after the new start; correct results.
- Spurious ready: force `sbox_drdy_o`=1 while in `SB_IDLE` and `SB_ISSUE` → buffer unchanged, `idx` unchanged.
